// File: rtl/caster_pkg.sv
// Shared encodings, state-word layout and per-pixel waveform update for caster_pixproc.
// Optional macro CASTER_MONO_MODE_EN enables the fast-mono path (mode 1) in pix_update.
package caster_pkg;

   typedef enum logic [1:0] {
      MODE_LUT  = 2'd0,
      MODE_MONO = 2'd1,
      MODE_RSV2 = 2'd2,
      MODE_RSV3 = 2'd3
   } mode_e;

   localparam logic [1:0] DRV_NOP   = 2'b00;
   localparam logic [1:0] DRV_DARK  = 2'b01;
   localparam logic [1:0] DRV_LIGHT = 2'b10;

   localparam int unsigned ST_MODE_HI = 15;
   localparam int unsigned ST_MODE_LO = 14;
   localparam int unsigned ST_LUT_ID  = 13;
   localparam int unsigned ST_FCNT_HI = 9;
   localparam int unsigned ST_FCNT_LO = 4;
   localparam int unsigned ST_PREV_HI = 3;
   localparam int unsigned ST_PREV_LO = 0;

   localparam int unsigned CASTER_FCNT_W = 6;
   localparam int unsigned RAM_AW        = 15;

   typedef struct packed {
      logic [1:0]  drive;
      logic [15:0] state;
   } pix_res_t;

   function automatic logic [RAM_AW-1:0] ram_addr(input logic id, input logic [3:0] prev,
                                                  input logic [3:0] tgt,
                                                  input logic [CASTER_FCNT_W-1:0] fcnt);
      return {id, prev, tgt, fcnt};
   endfunction

   // Counter wraps modulo 2^FCNT_W; prev is only written on an exact match with the last index.
   function automatic logic [15:0] advance(input logic [15:0] st, input logic [3:0] tgt,
                                           input logic [CASTER_FCNT_W-1:0] last);
      logic [15:0] r;
      r = st;
      if (st[ST_FCNT_HI:ST_FCNT_LO] == last) begin
         r[ST_PREV_HI:ST_PREV_LO] = tgt;
         r[ST_FCNT_HI:ST_FCNT_LO] = '0;
      end else begin
         r[ST_FCNT_HI:ST_FCNT_LO] = st[ST_FCNT_HI:ST_FCNT_LO] + CASTER_FCNT_W'(1);
      end
      return r;
   endfunction

   function automatic pix_res_t pix_update(input logic [15:0] st, input logic [3:0] tgt,
                                           input logic [1:0] code,
                                           input logic [CASTER_FCNT_W-1:0] lim0,
                                           input logic [CASTER_FCNT_W-1:0] lim1
`ifdef CASTER_MONO_MODE_EN
                                         , input logic [CASTER_FCNT_W-1:0] limm
`endif
                                           );
      pix_res_t r;
      logic     busy;
      r.drive = DRV_NOP;
      r.state = st;
      busy    = (st[ST_FCNT_HI:ST_FCNT_LO] != '0);
      case (mode_e'(st[ST_MODE_HI:ST_MODE_LO]))
         MODE_LUT: begin
            if (busy || (tgt != st[ST_PREV_HI:ST_PREV_LO])) begin
               r.drive = code;
               r.state = advance(st, tgt, st[ST_LUT_ID] ? lim1 : lim0);
            end
         end
`ifdef CASTER_MONO_MODE_EN
         MODE_MONO: begin
            if (busy || (tgt[3] != st[ST_PREV_HI])) begin
               r.drive = tgt[3] ? DRV_LIGHT : DRV_DARK;
               r.state = advance(st, tgt, limm);
            end
         end
`endif
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/caster_wvfm_ram.sv
// 32K x 2 waveform RAM: write on port A, two registered read ports sharing one read enable.
module caster_wvfm_ram
   import caster_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [RAM_AW-1:0] i_waddr,
   input  logic [1:0]        i_wdata,
   input  logic              i_re,
   input  logic [RAM_AW-1:0] i_raddr_a,
   input  logic [RAM_AW-1:0] i_raddr_b,
   output logic [1:0]        o_rdata_a,
   output logic [1:0]        o_rdata_b
);

   logic [1:0] r_mem [0:(1<<RAM_AW)-1];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (i_re) begin
         o_rdata_a <= r_mem[i_raddr_a];
         o_rdata_b <= r_mem[i_raddr_b];
      end
   end

endmodule

// File: rtl/caster_pixproc.sv
// Two-pixel-per-beat EPD waveform engine: 3-stage pipeline, state write-back and drive-code packer.
// Optional macro CASTER_MONO_MODE_EN enables fast-mono mode (mode 1).
module caster_pixproc
   import caster_pkg::*;
#(
   parameter int unsigned SD_WIDTH = 16,
   parameter int unsigned FCNT_W   = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic [5:0]          lut0_frames,
   input  logic [5:0]          lut1_frames,
   input  logic [5:0]          mono_frames,
   input  logic                lut_we,
   input  logic [14:0]         lut_waddr,
   input  logic [1:0]          lut_wdata,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [7:0]          in_target,
   input  logic [31:0]         in_state,
   output logic [31:0]         bo_pixel,
   output logic                bo_valid,
   output logic [SD_WIDTH-1:0] sd_data,
   output logic                sd_valid,
   input  logic                sd_ready
);

   localparam int unsigned     BEATS   = SD_WIDTH / 4;
   localparam int unsigned     PH_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(BEATS - 1);

   logic                w_en, w_accept;
   logic [FCNT_W-1:0]   r_lim0, r_lim1;
   logic [PH_W-1:0]     r_phase, w_beat_ph;
   logic [15:0]         w_in_st0, w_in_st1;
   logic                r_s0_valid, r_s0_last;
   logic [31:0]         r_s0_state;
   logic [7:0]          r_s0_tgt;
   logic [RAM_AW-1:0]   r_s0_addr_a, r_s0_addr_b;
   logic                r_s1_valid, r_s1_last;
   logic [31:0]         r_s1_state;
   logic [7:0]          r_s1_tgt;
   logic [1:0]          w_code_a, w_code_b;
   pix_res_t            w_res0, w_res1;
   logic [3:0]          w_nib;
   logic [SD_WIDTH-1:0] r_acc, w_acc_next;

   assign w_en      = !sd_valid | sd_ready;
   assign in_ready  = w_en & !rst & !lut_we;
   assign w_accept  = in_valid & in_ready;
   assign w_beat_ph = frame_start ? '0 : r_phase;
   assign w_in_st0  = in_state[15:0];
   assign w_in_st1  = in_state[31:16];

`ifdef CASTER_MONO_MODE_EN
   logic [FCNT_W-1:0] r_limm;
`else
   logic w_unused_mono;
   assign w_unused_mono = ^mono_frames;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lim0 <= '0;
         r_lim1 <= '0;
`ifdef CASTER_MONO_MODE_EN
         r_limm <= '0;
`endif
      end else if (frame_start) begin
         r_lim0 <= lut0_frames;
         r_lim1 <= lut1_frames;
`ifdef CASTER_MONO_MODE_EN
         r_limm <= mono_frames;
`endif
      end
   end

   // Beat position is fixed at accept so frame_start cannot disturb beats already in flight.
   always_ff @(posedge clk) begin
      if (rst)               r_phase <= '0;
      else if (w_accept)     r_phase <= (w_beat_ph == PH_LAST) ? '0 : w_beat_ph + PH_W'(1);
      else if (frame_start)  r_phase <= '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s0_valid  <= 1'b0;
         r_s0_last   <= 1'b0;
         r_s0_state  <= '0;
         r_s0_tgt    <= '0;
         r_s0_addr_a <= '0;
         r_s0_addr_b <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_state  <= '0;
         r_s1_tgt    <= '0;
      end else if (w_en) begin
         r_s0_valid <= w_accept;
         if (w_accept) begin
            r_s0_state  <= in_state;
            r_s0_tgt    <= in_target;
            r_s0_last   <= (w_beat_ph == PH_LAST);
            r_s0_addr_a <= ram_addr(w_in_st0[ST_LUT_ID], w_in_st0[ST_PREV_HI:ST_PREV_LO],
                                    in_target[3:0], w_in_st0[ST_FCNT_HI:ST_FCNT_LO]);
            r_s0_addr_b <= ram_addr(w_in_st1[ST_LUT_ID], w_in_st1[ST_PREV_HI:ST_PREV_LO],
                                    in_target[7:4], w_in_st1[ST_FCNT_HI:ST_FCNT_LO]);
         end
         r_s1_valid <= r_s0_valid;
         r_s1_last  <= r_s0_last;
         r_s1_state <= r_s0_state;
         r_s1_tgt   <= r_s0_tgt;
      end
   end

   caster_wvfm_ram u_ram (
      .clk       (clk),
      .i_we      (lut_we),
      .i_waddr   (lut_waddr),
      .i_wdata   (lut_wdata),
      .i_re      (w_en),
      .i_raddr_a (r_s0_addr_a),
      .i_raddr_b (r_s0_addr_b),
      .o_rdata_a (w_code_a),
      .o_rdata_b (w_code_b)
   );

   always_comb begin
`ifdef CASTER_MONO_MODE_EN
      w_res0 = pix_update(r_s1_state[15:0],  r_s1_tgt[3:0], w_code_a, r_lim0, r_lim1, r_limm);
      w_res1 = pix_update(r_s1_state[31:16], r_s1_tgt[7:4], w_code_b, r_lim0, r_lim1, r_limm);
`else
      w_res0 = pix_update(r_s1_state[15:0],  r_s1_tgt[3:0], w_code_a, r_lim0, r_lim1);
      w_res1 = pix_update(r_s1_state[31:16], r_s1_tgt[7:4], w_code_b, r_lim0, r_lim1);
`endif
      w_nib      = {w_res0.drive, w_res1.drive};
      // Shift-in packing: after BEATS beats any stale partial word has been shifted out.
      w_acc_next = (r_acc << 4) | SD_WIDTH'(w_nib);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bo_valid <= 1'b0;
         bo_pixel <= '0;
         r_acc    <= '0;
         sd_valid <= 1'b0;
         sd_data  <= '0;
      end else begin
         bo_valid <= w_en & r_s1_valid;
         if (w_en & r_s1_valid) begin
            bo_pixel <= {w_res1.state, w_res0.state};
            r_acc    <= w_acc_next;
         end
         if (w_en) begin
            sd_valid <= r_s1_valid & r_s1_last;
            if (r_s1_valid & r_s1_last) sd_data <= w_acc_next;
         end
      end
   end

endmodule

// File: tb/tb_caster_pixproc.sv
// Directed self-checking bench for caster_pixproc; expected values are hand-computed constants.
// Mono expectations follow CASTER_MONO_MODE_EN as defined for the build.
module tb_caster_pixproc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic [5:0]  lut0_frames = 6'd3;
   logic [5:0]  lut1_frames = 6'd0;
   logic [5:0]  mono_frames = 6'd1;
   logic        lut_we = 1'b0;
   logic [14:0] lut_waddr = '0;
   logic [1:0]  lut_wdata = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_target = '0;
   logic [31:0] in_state = '0;
   logic [31:0] bo_pixel;
   logic        bo_valid;
   logic [15:0] sd_data;
   logic        sd_valid;
   logic        sd_ready = 1'b1;

   always #5 clk = ~clk;

   caster_pixproc #(.SD_WIDTH(16), .FCNT_W(6)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .lut0_frames(lut0_frames), .lut1_frames(lut1_frames), .mono_frames(mono_frames),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target), .in_state(in_state),
      .bo_pixel(bo_pixel), .bo_valid(bo_valid),
      .sd_data(sd_data), .sd_valid(sd_valid), .sd_ready(sd_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int          mon_bo_cnt = 0;
   logic [31:0] mon_bo_sum = '0;
   int          mon_sd_cnt = 0;
   logic [15:0] mon_sd [32];

   always @(negedge clk) begin
      if (!rst) begin
         if (bo_valid) begin
            mon_bo_cnt = mon_bo_cnt + 1;
            mon_bo_sum = mon_bo_sum + bo_pixel;
         end
         if (sd_valid && sd_ready) begin
            if (mon_sd_cnt < 32) mon_sd[mon_sd_cnt] = sd_data;
            mon_sd_cnt = mon_sd_cnt + 1;
         end
      end
   end

   logic [31:0] v_st [4];
   logic [7:0]  v_tg [4];
   logic [31:0] v_bo [4];

   logic [15:0] tr_cur [5] = '{16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h000F};
   logic [15:0] tr_nxt [5] = '{16'h0010, 16'h0020, 16'h0030, 16'h000F, 16'h000F};
   logic [15:0] tr_sd  [5] = '{16'h8888, 16'h8888, 16'h8888, 16'h8888, 16'h0000};

`ifdef CASTER_MONO_MODE_EN
   logic [31:0] mo_st [2] = '{32'h4008_4000, 32'h4018_4010};
   logic [31:0] mo_bo [2] = '{32'h4018_4010, 32'h4000_4008};
   logic [15:0] mo_sd [2] = '{16'h9999, 16'h9999};
`else
   logic [31:0] mo_st [2] = '{32'h4008_4000, 32'h4008_4000};
   logic [31:0] mo_bo [2] = '{32'h4008_4000, 32'h4008_4000};
   logic [15:0] mo_sd [2] = '{16'h0000, 16'h0000};
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic lut_write(input logic [14:0] a, input logic [1:0] d);
      lut_we    = 1'b1;
      lut_waddr = a;
      lut_wdata = d;
      tick();
      lut_we    = 1'b0;
   endtask

   task automatic start_frame;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Drives (p0,p1): (01,10) (00,11) (10,10) (01,01) -> 0x63A5
   task automatic set_pack;
      v_st[0] = 32'h0002_0001; v_tg[0] = 8'h12; v_bo[0] = 32'h0012_0011;
      v_st[1] = 32'h0003_0005; v_tg[1] = 8'h45; v_bo[1] = 32'h0013_0005;
      v_st[2] = 32'h0002_0002; v_tg[2] = 8'h11; v_bo[2] = 32'h0012_0012;
      v_st[3] = 32'h0001_0001; v_tg[3] = 8'h22; v_bo[3] = 32'h0011_0011;
   endtask

   task automatic run_group(input string tag, input logic [15:0] exp_sd, input bit fs_first);
      for (int c = 0; c < 7; c++) begin
         if (c < 4) begin
            in_valid    = 1'b1;
            in_state    = v_st[c];
            in_target   = v_tg[c];
            frame_start = fs_first && (c == 0);
            #0 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         frame_start = 1'b0;
         if (c >= 2 && c < 6) begin
            check($sformatf("%s bo_valid%0d", tag, c - 2), 32'(bo_valid), 32'd1);
            check($sformatf("%s bo_pixel%0d", tag, c - 2), bo_pixel, v_bo[c-2]);
         end
         if (c == 4) check({tag, " sd_valid early"}, 32'(sd_valid), 32'd0);
         if (c == 5) begin
            check({tag, " sd_valid"}, 32'(sd_valid), 32'd1);
            check({tag, " sd_data"}, 32'(sd_data), 32'(exp_sd));
         end
         if (c == 6) begin
            check({tag, " bo_valid end"}, 32'(bo_valid), 32'd0);
            check({tag, " sd_valid end"}, 32'(sd_valid), 32'd0);
         end
      end
   endtask

   initial begin
      int          idx;
      int          base_bo, base_sd, snap;
      logic [31:0] base_sum, exp_sum;
      bit          acc;

      tick();
      tick();
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst bo_valid", 32'(bo_valid), 32'd0);
      check("rst bo_pixel", bo_pixel, 32'd0);
      check("rst sd_valid", 32'(sd_valid), 32'd0);
      check("rst sd_data", 32'(sd_data), 32'd0);
      rst = 1'b0;
      tick();

      lut_we = 1'b1;
      #1 check("lut_we in_ready", 32'(in_ready), 32'd0);
      for (int f = 0; f < 4; f++) lut_write({1'b0, 4'd0, 4'd15, 6'(f)}, 2'b10);
      lut_write({1'b0, 4'd1, 4'd2, 6'd0}, 2'b01);
      lut_write({1'b0, 4'd2, 4'd1, 6'd0}, 2'b10);
      lut_write({1'b0, 4'd3, 4'd4, 6'd0}, 2'b11);
      tick();

      for (int b = 0; b < 4; b++) begin
         v_st[b] = 32'h0005_0005; v_tg[b] = 8'h55; v_bo[b] = 32'h0005_0005;
      end
      start_frame();
      run_group("idle", 16'h0000, 1'b0);

      for (int f = 0; f < 5; f++) begin
         for (int b = 0; b < 4; b++) begin
            v_st[b] = {16'h0005, tr_cur[f]};
            v_tg[b] = 8'h5F;
            v_bo[b] = {16'h0005, tr_nxt[f]};
         end
         start_frame();
         run_group($sformatf("trans%0d", f), tr_sd[f], 1'b0);
      end

      for (int f = 0; f < 2; f++) begin
         for (int b = 0; b < 4; b++) begin
            v_st[b] = mo_st[f]; v_tg[b] = 8'h08; v_bo[b] = mo_bo[f];
         end
         start_frame();
         run_group($sformatf("mono%0d", f), mo_sd[f], 1'b0);
      end

      set_pack();
      start_frame();
      run_group("pack", 16'h63A5, 1'b0);

      start_frame();
      base_bo  = mon_bo_cnt;
      base_sum = mon_bo_sum;
      base_sd  = mon_sd_cnt;
      exp_sum  = v_bo[0] + v_bo[1] + v_bo[2] + v_bo[3] + 32'h0014_0014;
      idx = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         sd_ready = !(cyc >= 6 && cyc < 11);
         in_valid = (idx < 8);
         if (idx < 8) begin
            in_state  = (idx < 4) ? v_st[idx] : 32'h0005_0005;
            in_target = (idx < 4) ? v_tg[idx] : 8'h55;
         end
         #1;
         acc = in_valid && in_ready;
         if (!sd_ready) begin
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp sd_hold", 32'(sd_data), 32'h63A5);
         end
         tick();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      sd_ready = 1'b1;
      tick();
      check("bp accepted", 32'(idx), 32'd8);
      check("bp bo count", 32'(mon_bo_cnt - base_bo), 32'd8);
      check("bp bo sum", mon_bo_sum - base_sum, exp_sum);
      check("bp sd count", 32'(mon_sd_cnt - base_sd), 32'd2);
      if (mon_sd_cnt - base_sd >= 2) begin
         check("bp sd word0", 32'(mon_sd[base_sd]), 32'h63A5);
         check("bp sd word1", 32'(mon_sd[base_sd+1]), 32'h0000);
      end

      start_frame();
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_state = v_st[c]; in_target = v_tg[c];
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("mrst bo_valid", 32'(bo_valid), 32'd0);
      check("mrst bo_pixel", bo_pixel, 32'd0);
      check("mrst sd_valid", 32'(sd_valid), 32'd0);
      check("mrst sd_data", 32'(sd_data), 32'd0);
      check("mrst in_ready", 32'(in_ready), 32'd0);
      snap = mon_bo_cnt;
      rst = 1'b0;
      tick(); tick(); tick();
      check("mrst no bo_valid", 32'(mon_bo_cnt), 32'(snap));

      start_frame();
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; in_state = 32'h0005_0005; in_target = 8'h55;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick(); tick();
      check("partial sd_valid", 32'(sd_valid), 32'd0);
      set_pack();
      run_group("discard", 16'h63A5, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/caster_pixproc.md
# caster_pixproc

Per-pixel waveform engine between the framebuffer/video join and the EPD scan timing generator. Each beat carries two target grey levels and their two 16-bit pixel-state words. For each beat the block looks up the 2-bit source-driver code for each pixel, writes the updated state words back to the framebuffer, and packs the drive codes into `SD_WIDTH`-bit words that feed the source-driver data bus.

## Interface

Parameters:
- `SD_WIDTH`, default 16: source data word width. Must be a multiple of 4. Pixels per word = `SD_WIDTH`/2.
- `FCNT_W`, default 6: frame-counter width, equal to state bits 9:4.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_start` in 1: single-cycle pulse before the first beat of each frame. Clears the packer phase and latches the three frame-count inputs.
- `lut0_frames` in 6: last frame index of LUT 0.
- `lut1_frames` in 6: last frame index of LUT 1.
- `mono_frames` in 6: last frame index of fast mono mode.
- `lut_we` in 1: waveform RAM write strobe.
- `lut_waddr` in 15: waveform RAM write address, `{lut_id, prev[3:0], target[3:0], fcnt[5:0]}`.
- `lut_wdata` in 2: drive code to store.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accept.
- `in_target` in 8: pixel0 target in [3:0], pixel1 target in [7:4].
- `in_state` in 32: pixel0 state in [15:0], pixel1 state in [31:16].
- `bo_pixel` out 32: updated state words, same layout as `in_state`.
- `bo_valid` out 1: one-cycle strobe. Has no backpressure.
- `sd_data` out `SD_WIDTH`: packed drive codes. Pixel 0 of the group is in the MSBs [SD_WIDTH-1:SD_WIDTH-2].
- `sd_valid` out 1: `sd_data` is valid.
- `sd_ready` in 1: consumer accept.

## Operation

State word fields:
- [15:14] mode.
- [13] LUT id.
- [12:10] reserved; pass through unchanged.
- [9:4] `fcnt`.
- [3:0] `prev`.

Drive codes:
- 00 = no-op.
- 01 = darken.
- 10 = lighten.
- 11 = no-op.

Per pixel, mode 0 (LUT mode):
- Idle when `fcnt`==0 and `target`==`prev`: drive 00, state unchanged.
- Otherwise: drive = RAM[{id, prev, target, fcnt}].
  - If `fcnt`==last index of that LUT id: `prev`<=`target`, `fcnt`<=0.
  - Else `fcnt`<=`fcnt`+1.

Per pixel, mode 1 (fast mono):
- Idle when `fcnt`==0 and `target`[3]==`prev`[3]: drive 00, state unchanged.
- Otherwise drive = `target`[3] ? 10 : 01.
  - If `fcnt`==`mono_frames`: `prev`<=`target`, `fcnt`<=0.
  - Else `fcnt`<=`fcnt`+1.

Modes 2 and 3: drive 00, state unchanged.

General rules:
- `target` is sampled every frame. A target change mid-transition does not restart `fcnt`; the LUT address simply uses the new target.
- `fcnt` arithmetic is `FCNT_W`-bit. Completion compares with ==. A counter above the last index (limits changed between frames) wraps through 63→0 and never writes `prev` on the wrap.
- A last index of 0 means a one-frame waveform.
- The packer accumulates `SD_WIDTH`/4 beats per word. Beat k of a group lands at bits [SD_WIDTH-1-4k -: 4], with pixel0 above pixel1.
- `frame_start` discards any partial word. Row widths are multiples of `SD_WIDTH`/2 pixels, so a discard is an upstream error, not a flush.
- Waveform RAM writes are legal only between frames.
  - `lut_we` forces `in_ready`=0.
  - A write coinciding with a pipeline read has priority; the read result for that cycle is undefined. The bench must not do this.

## Timing

- Three stages:
  - S0: accept; the state and RAM address are registered.
  - S1: RAM data and computed state.
  - S2: outputs.
- Global enable `en` = !`sd_valid` | `sd_ready`. All stages advance only when `en` is high. RAM read-enable = `en`, so RAM output holds while stalled.
- `in_ready` = `en` & !`rst` & !`lut_we` (combinational).
- `bo_valid`<=`en` & S1 valid. It is high for exactly one cycle per beat, two edges after acceptance.
- The fourth beat of a 16-bit group accepted at edge N gives `sd_valid` high from edge N+2. `sd_valid` and `sd_data` then hold until `sd_ready`.
- Throughput is one beat per clock when `sd_ready` is held high.
- Reset values:
  - `sd_valid`=0, `sd_data`=0.
  - `bo_valid`=0, `bo_pixel`=0.
  - Packer phase 0; all stage valids 0.
  - Latched frame limits 0.
  - RAM contents are not reset.
- Reset mid-frame drops all in-flight beats without emitting `bo_valid`.
- `frame_start` coinciding with an accept: the clear applies first, and the beat becomes beat 0 of the new frame.

## Configuration

- `CASTER_MONO_MODE_EN` defined: mode 1 behaves as described under Operation.
- `CASTER_MONO_MODE_EN` undefined: mode 1 is treated as reserved (drive 00, state unchanged). `mono_frames` is ignored, and its comparator and mux are removed.

## Structure

- `caster_pkg`:
  - Mode encodings.
  - Drive-code constants.
  - State field bit positions.
  - RAM address packing function.
- One sub-module, `caster_wvfm_ram`: 32K×2 RAM with write port on A, registered dual read ports (A and B, one per pixel), and a shared read enable.
- Per-pixel update logic is a package function instantiated twice.

## Test plan

- Mode-0 idle: state 0x0005, target 5 → drive 00, `bo_pixel` word 0x0005.
- Mode-0 transition: RAM[{0,0,15,f}]=10 for all f, `lut0_frames`=3, state 0x0000, target 15 → four frames drive 10; `fcnt` reads 1, 2, 3, then 0 with `prev`=15 (final state 0x000F).
- Fast mono: state 0x4000, target 8, `mono_frames`=1 → drive 10 for two frames, final state 0x4008. Without the macro → drive 00 and state 0x4000 unchanged.
- Packing: 4 beats with drives (p0,p1) = (01,10), (00,11), (10,10), (01,01) → `sd_data`=0x63A5, valid two edges after beat 4.
- Backpressure: `sd_ready`=0 for 5 cycles mid-stream → `in_ready` low, `sd_data` stable, no lost or duplicated `bo_valid` (count equals beats accepted).
- Reset at cycle 3 of a group → all outputs 0 next cycle, no `bo_valid`. Next word after `frame_start` starts at beat 0.
